// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ID_W   = 2;
   localparam int unsigned HOLD_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage : rr_arbiter_4_pkg

// File: rtl/decoder_24.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder_24 (
   input  logic       d_en,
   input  logic [1:0] din,
   output logic [3:0] dout
);

   // Drive exactly one output bit when enabled, none otherwise.
   always_comb begin
      dout = '0;
      if (d_en) begin
         dout[din] = 1'b1;
      end
   end

endmodule : decoder_24

// File: rtl/rr_arbiter_4.sv
// 4-requester round-robin arbiter with done-based release and a hold limit
// that only forces a handoff while another requester is waiting.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_id
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_REQ - 1);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic [N_REQ-1:0]   others;
   logic               release_c;
   logic [ID_W-1:0]    pick_idle;
   logic [ID_W-1:0]    pick_next;

   // First set bit of r searched upward from (from+1) with wrap-around.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  from);
      logic [ID_W-1:0] idx;
      logic            found;
      rr_pick = '0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = ID_W'(int'(from) + int'(k));
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Release decision and round-robin winners for both states.
   always_comb begin
      others         = req;
      others[id_q]   = 1'b0;
      release_c      = done | ~req[id_q] | ((hold_q == HOLD_LAST) & (|others));
      pick_idle      = rr_pick(req, last_q);
      // Searching from the current holder skips it, since its bit is cleared in others.
      pick_next      = rr_pick(others, id_q);
   end

   // Next-state: arbitration from IDLE, release/handoff and hold counting in GRANT.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      last_d  = last_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               id_d    = pick_idle;
               last_d  = pick_idle;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (release_c) begin
               hold_d = '0;
               if (|others) begin
                  id_d   = pick_next;
                  last_d = pick_next;
               end else begin
                  // A done with the holder still requesting also lands here;
                  // it is re-granted from IDLE one cycle later.
                  state_d = IDLE;
                  id_d    = '0;
               end
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset leaves requester 0 with first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         last_q  <= ID_LAST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt_valid = (state_q == GRANT);
   assign gnt_id    = id_q;

   decoder_24 u_gnt_dec (
      .d_en (gnt_valid),
      .din  (gnt_id),
      .dout (gnt)
   );

endmodule : rr_arbiter_4

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, the maximum number of consecutive cycles one grant is held while another requester is pending; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4, request lines; bit i is requester i.
REQ-005 The block SHALL have port done, input, 1, a release pulse from the current grant holder.
REQ-006 The block SHALL have port gnt, output, 4, the one-hot grant; it is all-zero when idle.
REQ-007 The block SHALL have port gnt_valid, output, 1, high whenever any gnt bit is high.
REQ-008 The block SHALL have port gnt_id, output, 2, the binary index of the current grant; it is 0 when idle.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-010 In IDLE with req != 0 at a rising edge, the block SHALL enter GRANT at that edge; gnt is registered with 1-cycle latency from req to gnt.
REQ-011 The winner SHALL be the first set req bit searched from (last_id+1) mod 4 upward with wrap-around; last_id is the most recently granted index.
REQ-012 Release SHALL occur at an edge where, in GRANT, done=1, or req[gnt_id]=0, or (hold_cnt = MAX_HOLD-1 and another req bit is set).
REQ-013 On release, if any other req bit is set, the block SHALL hand off directly to the next round-robin winner at the same edge, with no idle cycle.
REQ-014 On release, if no other req bit is set, the block SHALL go to IDLE, except in the case given in REQ-015.
REQ-015 On release by done while req[gnt_id] is still set and no other requester is pending, the block SHALL return to IDLE for one cycle and then re-grant the same requester.
REQ-016 hold_cnt SHALL clear on every new grant and increment each cycle in GRANT.
REQ-017 hold_cnt SHALL saturate at MAX_HOLD-1; when no other requester is pending, no forced release occurs.
REQ-018 When done and the timeout occur in the same cycle, they SHALL be treated as a single release.
REQ-019 done SHALL be ignored in IDLE.
REQ-020 Changes on req bits that are not granted SHALL NOT affect the current grant; they are only sampled at arbitration edges.
REQ-021 gnt SHALL be the decode of gnt_id qualified by gnt_valid, so gnt is always one-hot or zero.

Reset
REQ-022 Assertion of rst SHALL immediately, without waiting for clk, force state=IDLE, gnt=0000, gnt_valid=0, gnt_id=0, hold_cnt=0, last_id=3, so that requester 0 has first priority.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately.
REQ-024 After rst deasserts, the first arbitration SHALL occur at the first rising edge with req != 0.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, GRANT), the requester count constant 4 and the index width constant 2.
REQ-026 The gnt decode SHALL be one instance of the existing 2-to-4 decoder module decoder_24, with d_en=gnt_valid and din=gnt_id.
REQ-027 All other logic SHALL be in rr_arbiter_4: the state register, round-robin priority search, hold counter and last_id register.

Verification
REQ-028 The bench SHALL cover reset then req=0100: gnt=0100, gnt_id=2 on the cycle after the edge; hold req and done=0 -> gnt stays 0100 indefinitely.
REQ-029 The bench SHALL cover req=1111 with done pulsed every 3 cycles: grant order 0,1,2,3,0, each handoff with no gap.
REQ-030 The bench SHALL cover MAX_HOLD=4, req=0011, done never asserted: gnt=0001 for 4 cycles, then 0010 for 4 cycles, alternating.
REQ-031 The bench SHALL cover granted requester 1 dropping req[1] with req=1000 pending: next cycle gnt=1000; then drop all req -> gnt=0000, gnt_valid=0.
REQ-032 The bench SHALL cover rst asserted mid-GRANT between clock edges: gnt=0000 before the next edge; after release, req=0010 -> gnt=0010 after one edge.
REQ-033 The bench SHALL cover done with req=0001 held alone: gnt 0001 -> 0000 for 1 cycle -> 0001; continuously assert gnt one-hot-or-zero and gnt_valid == |gnt.
